// File: rtl/fifo_flags_pkg.sv
// Shared definitions for fifo_flags: per-cycle operation encoding and read-mode constants.
package fifo_flags_pkg;

  // Accepted operation in a cycle, packed as {wr_ok, rd_ok}
  typedef enum logic [1:0] {
    OP_IDLE      = 2'b00,
    OP_READ      = 2'b01,
    OP_WRITE     = 2'b10,
    OP_READWRITE = 2'b11
  } fifo_op_e;

  // Read-mode selection for the FWFT parameter
  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

endpackage

// File: rtl/fifo_flags_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_flags_ram #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned PTR_LEN = 4
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [PTR_LEN-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [PTR_LEN-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 1 << PTR_LEN;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  // Write port; contents deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// selectable FWFT/registered read, synchronous flush and sticky error flags.
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int unsigned NB_DATA  = 8,
  parameter int unsigned PTR_LEN  = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_clear_err,
  input  logic               i_write_fifo,
  input  logic [NB_DATA-1:0] i_data_to_write,
  input  logic               i_read_fifo,
  output logic [NB_DATA-1:0] o_data_to_read,
  output logic               o_data_valid,
  output logic               o_fifo_is_empty,
  output logic               o_fifo_is_full,
  output logic               o_almost_empty,
  output logic               o_almost_full,
  output logic [PTR_LEN:0]   o_count,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int unsigned DEPTH = 1 << PTR_LEN;
  localparam int unsigned CW    = PTR_LEN + 1;

  // Threshold ordering must leave room between almost-empty and almost-full
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("fifo_flags: require AE_LEVEL < AF_LEVEL <= 2**PTR_LEN");
  end

  logic [PTR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               ae_q, ae_d;
  logic               af_q, af_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [NB_DATA-1:0] dout_q, dout_d;
  logic               dvalid_q, dvalid_d;

  logic               rd_ok;
  logic               wr_ok;
  logic               ram_wr_en;
  fifo_op_e           op;
  logic [NB_DATA-1:0] rd_data;

  fifo_flags_ram #(
    .NB_DATA (NB_DATA),
    .PTR_LEN (PTR_LEN)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (ram_wr_en),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_data_to_write),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (rd_data)
  );

  // Accept decisions, pointer/count update, flag and output-register next state
  always_comb begin
    rd_ok     = i_read_fifo & ~empty_q;
    wr_ok     = i_write_fifo & (~full_q | rd_ok);
    op        = fifo_op_e'({wr_ok, rd_ok});
    ram_wr_en = wr_ok & ~i_flush;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (op)
        OP_IDLE: ;
        OP_READ: begin
          rd_ptr_d = rd_ptr_q + PTR_LEN'(1);
          count_d  = count_q - CW'(1);
        end
        OP_WRITE: begin
          wr_ptr_d = wr_ptr_q + PTR_LEN'(1);
          count_d  = count_q + CW'(1);
        end
        OP_READWRITE: begin
          rd_ptr_d = rd_ptr_q + PTR_LEN'(1);
          wr_ptr_d = wr_ptr_q + PTR_LEN'(1);
        end
      endcase
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    ae_d    = (count_d <= CW'(AE_LEVEL));
    af_d    = (count_d >= CW'(AF_LEVEL));

    // A flushed cycle discards requests without reporting them as errors
    ovf_d = (ovf_q & ~i_clear_err) | (i_write_fifo & ~wr_ok & ~i_flush);
    unf_d = (unf_q & ~i_clear_err) | (i_read_fifo & ~rd_ok & ~i_flush);

    dvalid_d = rd_ok & ~i_flush;
    dout_d   = dvalid_d ? rd_data : dout_q;
  end

  // State registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= (AF_LEVEL == 0);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // FWFT exposes the head word directly; otherwise the registered copy
  assign o_data_to_read  = (FWFT == FWFT_ON) ? rd_data : dout_q;
  assign o_data_valid    = (FWFT == FWFT_ON) ? ~empty_q : dvalid_q;
  assign o_fifo_is_empty = empty_q;
  assign o_fifo_is_full  = full_q;
  assign o_almost_empty  = ae_q;
  assign o_almost_full   = af_q;
  assign o_count         = count_q;
  assign o_overflow      = ovf_q;
  assign o_underflow     = unf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: one FWFT and one registered-read instance on shared stimulus.
module tb_fifo_flags;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       clear_err;
  logic       wr;
  logic [7:0] wdata;
  logic       rd;

  logic [7:0] f_data, r_data;
  logic       f_valid, r_valid;
  logic       f_empty, r_empty, f_full, r_full;
  logic       f_ae, r_ae, f_af, r_af;
  logic [4:0] f_count, r_count;
  logic       f_ovf, r_ovf, f_unf, r_unf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_q[$];

  fifo_flags #(
    .NB_DATA(8), .PTR_LEN(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)
  ) dut_f (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_clear_err(clear_err),
    .i_write_fifo(wr), .i_data_to_write(wdata), .i_read_fifo(rd),
    .o_data_to_read(f_data), .o_data_valid(f_valid),
    .o_fifo_is_empty(f_empty), .o_fifo_is_full(f_full),
    .o_almost_empty(f_ae), .o_almost_full(f_af), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  fifo_flags #(
    .NB_DATA(8), .PTR_LEN(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)
  ) dut_r (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_clear_err(clear_err),
    .i_write_fifo(wr), .i_data_to_write(wdata), .i_read_fifo(rd),
    .o_data_to_read(r_data), .o_data_valid(r_valid),
    .o_fifo_is_empty(r_empty), .o_fifo_is_full(r_full),
    .o_almost_empty(r_ae), .o_almost_full(r_af), .o_count(r_count),
    .o_overflow(r_ovf), .o_underflow(r_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock with the given requests; outputs are sampled 1ns after the edge
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic fl, input logic ce);
    wr = w; wdata = d; rd = r; flush = fl; clear_err = ce;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clear_err = 1'b0; wdata = 8'h00;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clear_err = 1'b0; wr = 1'b0; wdata = 8'h00; rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(f_count), 32'd0);
    check("rst_empty", 32'(f_empty), 32'd1);
    check("rst_full", 32'(f_full), 32'd0);
    check("rst_ae", 32'(f_ae), 32'd1);
    check("rst_af", 32'(f_af), 32'd0);
    check("rst_ovf", 32'(f_ovf), 32'd0);
    check("rst_unf", 32'(f_unf), 32'd0);
    check("rst_fvalid", 32'(f_valid), 32'd0);
    check("rst_rvalid", 32'(r_valid), 32'd0);
    check("rst_rdata", 32'(r_data), 32'd0);
    rst = 1'b0;

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      check("fill_count", 32'(f_count), 32'(i + 1));
      check("fill_af", 32'(f_af), 32'((i + 1) >= 12));
      check("fill_full", 32'(f_full), 32'((i + 1) == 16));
      check("fill_empty", 32'(f_empty), 32'd0);
    end
    check("fill_r_count", 32'(r_count), 32'd16);

    // Write into a full FIFO is rejected
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(f_ovf), 32'd1);
    check("ovf_count", 32'(f_count), 32'd16);
    check("ovf_head", 32'(f_data), 32'h00);
    check("ovf_no_unf", 32'(f_unf), 32'd0);

    // Drain: FWFT shows head before pop, registered mode shows it after
    for (int i = 0; i < 16; i++) begin
      check("drain_fdata", 32'(f_data), 32'(i));
      check("drain_fvalid", 32'(f_valid), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("drain_count", 32'(f_count), 32'(15 - i));
      check("drain_ae", 32'(f_ae), 32'((15 - i) <= 2));
      check("drain_empty", 32'(f_empty), 32'((15 - i) == 0));
      check("drain_rdata", 32'(r_data), 32'(i));
      check("drain_rvalid", 32'(r_valid), 32'd1);
    end
    check("drain_fvalid_end", 32'(f_valid), 32'd0);

    // Read from empty is rejected
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("unf_set", 32'(f_unf), 32'd1);
    check("unf_count", 32'(f_count), 32'd0);
    check("unf_rvalid", 32'(r_valid), 32'd0);
    check("unf_rhold", 32'(r_data), 32'h0F);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("clr_ovf", 32'(f_ovf), 32'd0);
    check("clr_unf", 32'(f_unf), 32'd0);

    // Full FIFO with simultaneous read+write across pointer wrap
    model_q.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      model_q.push_back(8'(8'h10 + i));
    end
    check("rw_full_pre", 32'(f_full), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("rw_head", 32'(f_data), 32'(model_q[0]));
      cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      void'(model_q.pop_front());
      model_q.push_back(8'hAA);
      check("rw_count", 32'(f_count), 32'd16);
      check("rw_full", 32'(f_full), 32'd1);
      check("rw_ovf", 32'(f_ovf), 32'd0);
    end
    check("rw_head_end", 32'(f_data), 32'hAA);

    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("flush_count", 32'(f_count), 32'd0);
    check("flush_empty", 32'(f_empty), 32'd1);
    check("flush_full", 32'(f_full), 32'd0);

    // Empty FIFO with simultaneous read+write
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("erw_count", 32'(f_count), 32'd1);
    check("erw_unf", 32'(f_unf), 32'd1);
    check("erw_fdata", 32'(f_data), 32'h55);
    check("erw_fvalid", 32'(f_valid), 32'd1);
    check("erw_rvalid", 32'(r_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("erw_clr", 32'(f_unf), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("erw_pop_count", 32'(f_count), 32'd0);

    // Registered read latency and hold
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("reg_pre_valid", 32'(r_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("reg_valid", 32'(r_valid), 32'd1);
    check("reg_data", 32'(r_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reg_valid_drop", 32'(r_valid), 32'd0);
    check("reg_hold", 32'(r_data), 32'h3C);

    // Clear in the same cycle as a new underflow keeps the flag
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("clr_vs_new", 32'(f_unf), 32'd1);

    // Count 7, flush with concurrent write
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    check("pre_flush_count", 32'(f_count), 32'd7);
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    check("fw_count", 32'(f_count), 32'd0);
    check("fw_empty", 32'(f_empty), 32'd1);
    check("fw_ae", 32'(f_ae), 32'd1);
    check("fw_unf_kept", 32'(f_unf), 32'd1);
    check("fw_no_ovf", 32'(f_ovf), 32'd0);
    check("fw_fvalid", 32'(f_valid), 32'd0);

    // Async reset mid-burst, checked before the next clock edge
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    check("burst_count", 32'(f_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(f_count), 32'd0);
    check("arst_empty", 32'(f_empty), 32'd1);
    check("arst_unf", 32'(f_unf), 32'd0);
    check("arst_rdata", 32'(r_data), 32'd0);
    check("arst_rvalid", 32'(r_valid), 32'd0);
    check("arst_fvalid", 32'(f_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", 32'(r_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised successor to the team's synchronous FIFO: single-clock circular buffer, depth 2^PTR_LEN, with occupancy count, programmable almost-full/almost-empty thresholds, selectable read mode (first-word-fall-through or registered output), synchronous flush, and sticky overflow/underflow error flags. It sits between the UART RX/TX datapaths and the ALU command/result logic wherever back-pressure must be signalled early.

## Interface
- NB_DATA, 8, data width in bits
- PTR_LEN, 4, pointer width; depth = 2^PTR_LEN
- AF_LEVEL, 12, o_almost_full asserted when count >= AF_LEVEL (1..2^PTR_LEN)
- AE_LEVEL, 2, o_almost_empty asserted when count <= AE_LEVEL (0..2^PTR_LEN-1)
- FWFT, 1, 1 = first-word-fall-through, 0 = registered read data
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_flush  in  1  synchronous empty request
- i_clear_err  in  1  synchronous clear of sticky error flags
- i_write_fifo  in  1  write request
- i_data_to_write  in  NB_DATA  write data
- i_read_fifo  in  1  read request / pop
- o_data_to_read  out  NB_DATA  read data
- o_data_valid  out  1  o_data_to_read holds valid data
- o_fifo_is_empty  out  1  count == 0
- o_fifo_is_full  out  1  count == 2^PTR_LEN
- o_almost_empty  out  1  count <= AE_LEVEL
- o_almost_full  out  1  count >= AF_LEVEL
- o_count  out  PTR_LEN+1  current occupancy, 0..2^PTR_LEN
- o_overflow  out  1  sticky: a write was rejected
- o_underflow  out  1  sticky: a read was rejected

## Operation
- Accept rules per cycle (evaluated on registered state): wr_ok = i_write_fifo & (~full | rd_ok); rd_ok = i_read_fifo & ~empty.
- Full + read + write: both accepted, count unchanged, pointers both advance.
- Empty + read + write: write accepted, read rejected (underflow set), count becomes 1.
- Rejected write: memory and pointers unchanged, o_overflow <= 1. Rejected read: pointers unchanged, o_underflow <= 1.
- count_next = count + wr_ok - rd_ok; computed at PTR_LEN+1 bits, never wraps. Pointers wrap modulo 2^PTR_LEN.
- All flags (empty, full, almost_*) are registered, derived from count_next; never decoded combinationally from o_count.
- i_flush: pointers, count to 0, flags to reset values at next edge; wins over any read/write in the same cycle (concurrent write discarded, no error flagged). Sticky errors not touched by flush.
- i_clear_err: clears both sticky flags; if a new error occurs in the same cycle, the flag stays set.
- FWFT=1: o_data_to_read = mem[read_ptr] combinationally; o_data_valid = ~o_fifo_is_empty; i_read_fifo acts as pop/ack.
- FWFT=0: on accepted read, mem[read_ptr] loaded into output register; o_data_valid high for exactly the following cycle; output register holds value otherwise.
- Memory contents are not reset.

## Timing
- Reset values: o_count 0, o_fifo_is_empty 1, o_fifo_is_full 0, o_almost_empty 1, o_almost_full 0 (1 if AF_LEVEL == 0, disallowed), o_overflow 0, o_underflow 0, o_data_valid 0, o_data_to_read 0 when FWFT=0 (undefined when FWFT=1 and empty).
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clock.
- Write at edge N: data readable, empty deasserted, o_count updated after edge N (FWFT=1: o_data_to_read valid in cycle N+1).
- FWFT=0 read latency: request at edge N, data and o_data_valid in cycle after N.
- Error flags set after the edge of the offending cycle.

## Structure
- Shared package/header fifo_defs: op encodings READ 2'b01, WRITE 2'b10, READWRITE 2'b11; mode constants FWFT_ON/FWFT_OFF.
- Sub-module fifo_ram: 2^PTR_LEN x NB_DATA array, one synchronous write port, one asynchronous read port. Top holds pointers, count, flags, output register.
- Parameter checks: AE_LEVEL < AF_LEVEL <= 2^PTR_LEN.

## Test plan
- Reset, write 16 words 0x00..0x0F, no reads -> o_count 16, full 1, almost_full 1 after 12th write, 17th write sets o_overflow, data unchanged.
- Read all 16 (FWFT=1) -> sequence 0x00..0x0F, almost_empty after count reaches 2, empty after 16th; extra read sets o_underflow.
- Full FIFO, simultaneous read+write 0xAA for 20 cycles -> count stays 16, no overflow, read order preserved across pointer wrap.
- Empty FIFO, read+write 0x55 same cycle -> count 1, o_underflow 1, next cycle o_data_to_read 0x55; i_clear_err clears flag.
- FWFT=0: write 0x3C, read at edge N -> o_data_valid and 0x3C in cycle N+1 only, output held afterwards.
- Count 7, assert i_flush with concurrent write, then async reset mid-burst -> count 0, empty 1, sticky flags kept after flush, all outputs at reset values after reset.
